dht11_scheduler: RTL and testbench
==================================

# dht11_scheduler

Measurement scheduler sitting between the DHT11 single-wire reader and the pet logic. Issues one read per period or on demand, supervises it with a timeout, retries failed or implausible readings, and holds the last good integer humidity and temperature. Drives hot/cold/humid condition flags with hysteresis. A fault flag is raised after repeated failures.

## Interface
- `PERIOD_CYCLES`, 250_000_000: cycles between scheduled read attempts (2 s at 125 MHz).
- `TIMEOUT_CYCLES`, 1_250_000: max cycles from `sens_start` to `sens_done` (10 ms).
- `RETRY_GAP`, 125_000_000: wait before a retry (1 s; DHT11 needs ≥1 s between reads).
- `MAX_RETRY`, 3: retries after a failed attempt before declaring fault.
- `TEMP_HOT`, 30 / `TEMP_COLD`, 15 / `HUM_HIGH`, 80 / `HYST`, 2: thresholds in °C / %RH.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: enables periodic reads; `req` still works when low.
- `req` in 1: one-cycle on-demand read request.
- `sens_start` out 1: one-cycle pulse starting a reader transaction.
- `sens_done` in 1: one-cycle pulse, reader finished; `sens_valid`/`sens_hum`/`sens_temp` qualified by it.
- `sens_valid` in 1: reader checksum passed.
- `sens_hum`, `sens_temp` in 16 each: {integer byte, decimal byte}.
- `hum_int`, `temp_int` out 8 each: last good integer values.
- `data_ok` out 1: at least one good sample held and no fault since.
- `new_sample` out 1: one-cycle pulse when outputs update.
- `fault` out 1: retries exhausted.
- `err_count` out 8: failed attempts, saturating at 255.
- `too_hot`, `too_cold`, `too_humid` out 1 each: condition flags.
- `state` out 3: FSM state for debug.

## Operation
- States: IDLE=0, START=1, WAIT=2, EVAL=3, BACKOFF=4.
- IDLE: the period counter runs while `en` is high.
  - Go to START when the counter reaches `PERIOD_CYCLES`-1 or when `req` is high.
  - `req` is ignored in all other states; there is no queueing.
- START: `sens_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: count cycles.
  - On `sens_done`: capture the inputs and go to EVAL.
  - On timeout (count = `TIMEOUT_CYCLES`-1 without done): record a failure.
  - `sens_done` in the same cycle as timeout: done wins.
- EVAL: a sample is good when `sens_valid`=1, hum integer ≤ 100 and temp integer ≤ 60.
  - Good sample:
    - Load `hum_int`/`temp_int`, pulse `new_sample`.
    - Set `data_ok`; clear `fault` and the retry count.
    - Update flags, clear the period counter, go to IDLE.
- Failure (from EVAL or timeout):
  - Increment `err_count` (saturating) and the retry count.
  - If retry count ≤ `MAX_RETRY`, go to BACKOFF. Otherwise set `fault`, clear `data_ok`, clear the retry count, clear the period counter, and go to IDLE.
  - `hum_int`/`temp_int` keep their last good values.
- BACKOFF: wait `RETRY_GAP` cycles, then go to START.
- Flags with hysteresis (evaluated only on good samples):
  - `too_hot` sets when temp ≥ `TEMP_HOT` and clears when temp < `TEMP_HOT`-`HYST`.
  - `too_cold` sets when temp ≤ `TEMP_COLD` and clears when temp > `TEMP_COLD`+`HYST`.
  - `too_humid` sets when hum ≥ `HUM_HIGH` and clears when hum < `HUM_HIGH`-`HYST`.
- Arithmetic: 8-bit unsigned compares. Threshold arithmetic is done in parameters and must not underflow.

## Timing
- Reset values: all outputs 0, `state`=IDLE, all counters 0. Reset mid-WAIT drops the transaction.
- `req` high at edge k in IDLE gives `sens_start`=1 during cycle k+1.
- `sens_done` sampled at edge k gives EVAL in cycle k+1. Outputs, flags and `new_sample` are registered at edge k+2 (2-cycle latency).
- `sens_done` outside WAIT is ignored.
- The period is measured from the end of the previous attempt. First scheduled read is `PERIOD_CYCLES` after reset.
- Counter widths are `$clog2` of the largest of `PERIOD_CYCLES`, `RETRY_GAP` and `TIMEOUT_CYCLES`.

## Structure
- Shared package `dht11_pkg`: state encodings, byte-field constants (integer byte = [15:8]), plausibility limits 100/60.
- Sub-module `hyst_flag` (value, set/clear thresholds, direction): instantiated three times.
- Remainder is one FSM file.

## Test plan
Use small parameters: PERIOD=100, TIMEOUT=20, RETRY_GAP=10, MAX_RETRY=3, HYST=2.
- Good read: `req`, reader returns done with valid=1, hum=0x3700, temp=0x1900. Expect `hum_int`=55, `temp_int`=25, `new_sample` pulse 2 cycles after done, `data_ok`=1.
- Checksum fail then success: valid=0 once, then good. Expect `err_count`=1, `sens_start` again 10 cycles after EVAL, `fault`=0.
- Reader silent: no `sens_done` ever. Expect 4 attempts, `err_count`=4, then `fault`=1 and `data_ok`=0. Values held.
- Implausible data: hum=0x7800 (120) with valid=1. Expect a failure and retry; outputs unchanged.
- Hysteresis on temp 30, 29, 28, 27 (good samples): `too_hot`=1,1,1,0. Temp 15 then 17 then 18: `too_cold`=1,1,0.
- Corner cases:
  - `sens_done` on the timeout cycle is treated as done.
  - `req` during WAIT is ignored.
  - `rst` in WAIT gives all outputs 0 next cycle.
  - `en`=1 produces `sens_start` every 100+attempt cycles.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared encodings and limits for the DHT11 measurement scheduler.
package dht11_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_EVAL    = 3'd3,
        S_BACKOFF = 3'd4
    } state_t;

    typedef enum logic {
        DIR_ABOVE = 1'b0,
        DIR_BELOW = 1'b1
    } flag_dir_t;

    // DHT11 words are {integer byte, decimal byte}
    localparam int INT_MSB = 15;
    localparam int INT_LSB = 8;

    localparam logic [7:0] HUM_MAX  = 8'd100;
    localparam logic [7:0] TEMP_MAX = 8'd60;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hyst_flag.sv
// Condition flag with hysteresis; only moves when a new good sample arrives.
module hyst_flag
    import dht11_pkg::*;
#(
    parameter flag_dir_t DIR = DIR_ABOVE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [7:0] value,
    input  logic [7:0] set_th,
    input  logic [7:0] clr_th,
    output logic       flag
);

    logic set_hit;
    logic clr_hit;

    assign set_hit = (DIR == DIR_ABOVE) ? (value >= set_th) : (value <= set_th);
    assign clr_hit = (DIR == DIR_ABOVE) ? (value <  clr_th) : (value >  clr_th);

    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (update) begin
            if (set_hit)
                flag <= 1'b1;
            else if (clr_hit)
                flag <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_scheduler.sv
// Periodic / on-demand DHT11 read scheduler with timeout, retry, fault tracking
// and hysteresis condition flags.
module dht11_scheduler
    import dht11_pkg::*;
#(
    parameter int          PERIOD_CYCLES  = 250_000_000,
    parameter int          TIMEOUT_CYCLES = 1_250_000,
    parameter int          RETRY_GAP      = 125_000_000,
    parameter int          MAX_RETRY      = 3,
    parameter int unsigned TEMP_HOT       = 30,
    parameter int unsigned TEMP_COLD      = 15,
    parameter int unsigned HUM_HIGH       = 80,
    parameter int unsigned HYST           = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req,
    output logic        sens_start,
    input  logic        sens_done,
    input  logic        sens_valid,
    input  logic [15:0] sens_hum,
    input  logic [15:0] sens_temp,
    output logic [7:0]  hum_int,
    output logic [7:0]  temp_int,
    output logic        data_ok,
    output logic        new_sample,
    output logic        fault,
    output logic [7:0]  err_count,
    output logic        too_hot,
    output logic        too_cold,
    output logic        too_humid,
    output logic [2:0]  state
);

    localparam int CNT_MAX = max3(PERIOD_CYCLES, RETRY_GAP, TIMEOUT_CYCLES);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    // Clear points clamp instead of wrapping when thresholds sit near 0 / 255
    localparam logic [7:0] HOT_SET  = 8'(TEMP_HOT);
    localparam logic [7:0] HOT_CLR  = (TEMP_HOT >= HYST) ? 8'(TEMP_HOT - HYST) : 8'd0;
    localparam logic [7:0] COLD_SET = 8'(TEMP_COLD);
    localparam logic [7:0] COLD_CLR = (TEMP_COLD + HYST > 255) ? 8'd255 : 8'(TEMP_COLD + HYST);
    localparam logic [7:0] HUM_SET  = 8'(HUM_HIGH);
    localparam logic [7:0] HUM_CLR  = (HUM_HIGH >= HYST) ? 8'(HUM_HIGH - HYST) : 8'd0;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          cap_valid;
    logic [7:0]    cap_hum;
    logic [7:0]    cap_temp;
    logic          good;
    logic          fail;
    logic          flag_upd;
    logic          unused_dec;

    assign unused_dec = ^{sens_hum[INT_LSB-1:0], sens_temp[INT_LSB-1:0]};

    assign good      = cap_valid && (cap_hum <= HUM_MAX) && (cap_temp <= TEMP_MAX);
    assign fail      = ((st == S_WAIT) && !sens_done && (cnt == TO_LAST)) ||
                       ((st == S_EVAL) && !good);
    assign flag_upd  = (st == S_EVAL) && good;
    assign retry_nxt = retry_cnt + 1'b1;
    assign state     = st;

    // One counter serves period (IDLE), timeout (WAIT) and backoff (BACKOFF);
    // it is cleared on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            cnt        <= '0;
            retry_cnt  <= '0;
            cap_valid  <= 1'b0;
            cap_hum    <= 8'd0;
            cap_temp   <= 8'd0;
            sens_start <= 1'b0;
            hum_int    <= 8'd0;
            temp_int   <= 8'd0;
            data_ok    <= 1'b0;
            new_sample <= 1'b0;
            fault      <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            sens_start <= 1'b0;
            new_sample <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (req || (en && cnt == PER_LAST)) begin
                        st         <= S_START;
                        sens_start <= 1'b1;
                        cnt        <= '0;
                    end else if (en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    st  <= S_WAIT;
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (sens_done) begin
                        cap_valid <= sens_valid;
                        cap_hum   <= sens_hum[INT_MSB:INT_LSB];
                        cap_temp  <= sens_temp[INT_MSB:INT_LSB];
                        st        <= S_EVAL;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (good) begin
                        hum_int    <= cap_hum;
                        temp_int   <= cap_temp;
                        new_sample <= 1'b1;
                        data_ok    <= 1'b1;
                        fault      <= 1'b0;
                        retry_cnt  <= '0;
                        cnt        <= '0;
                        st         <= S_IDLE;
                    end
                end
                S_BACKOFF: begin
                    if (cnt == GAP_LAST) begin
                        st         <= S_START;
                        sens_start <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st  <= S_IDLE;
                    cnt <= '0;
                end
            endcase

            // Timeout and rejected samples share one failure path
            if (fail) begin
                err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                cnt       <= '0;
                if (retry_nxt <= RETRY_LIM) begin
                    retry_cnt <= retry_nxt;
                    st        <= S_BACKOFF;
                end else begin
                    fault     <= 1'b1;
                    data_ok   <= 1'b0;
                    retry_cnt <= '0;
                    st        <= S_IDLE;
                end
            end
        end
    end

    hyst_flag #(.DIR(DIR_ABOVE)) u_hot (
        .clk(clk), .rst(rst), .update(flag_upd), .value(cap_temp),
        .set_th(HOT_SET), .clr_th(HOT_CLR), .flag(too_hot)
    );

    hyst_flag #(.DIR(DIR_BELOW)) u_cold (
        .clk(clk), .rst(rst), .update(flag_upd), .value(cap_temp),
        .set_th(COLD_SET), .clr_th(COLD_CLR), .flag(too_cold)
    );

    hyst_flag #(.DIR(DIR_ABOVE)) u_humid (
        .clk(clk), .rst(rst), .update(flag_upd), .value(cap_hum),
        .set_th(HUM_SET), .clr_th(HUM_CLR), .flag(too_humid)
    );

endmodule

// File: tb/tb_dht11_scheduler.sv
// Self-checking bench: directed sequences, a hysteresis vector table and
// randomized reads checked against a transaction-level model.
module tb_dht11_scheduler;

    localparam int P   = 100;
    localparam int TO  = 20;
    localparam int GAP = 10;
    localparam int MR  = 3;
    localparam int TH  = 30;
    localparam int TC  = 15;
    localparam int HH  = 80;
    localparam int HY  = 2;

    logic        clk = 1'b0;
    logic        rst, en, req, sens_done, sens_valid;
    logic [15:0] sens_hum, sens_temp;
    logic        sens_start, data_ok, new_sample, fault;
    logic        too_hot, too_cold, too_humid;
    logic [7:0]  hum_int, temp_int, err_count;
    logic [2:0]  state;

    dht11_scheduler #(
        .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(TO), .RETRY_GAP(GAP), .MAX_RETRY(MR),
        .TEMP_HOT(TH), .TEMP_COLD(TC), .HUM_HIGH(HH), .HYST(HY)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .sens_start(sens_start), .sens_done(sens_done), .sens_valid(sens_valid),
        .sens_hum(sens_hum), .sens_temp(sens_temp),
        .hum_int(hum_int), .temp_int(temp_int), .data_ok(data_ok),
        .new_sample(new_sample), .fault(fault), .err_count(err_count),
        .too_hot(too_hot), .too_cold(too_cold), .too_humid(too_humid),
        .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state
    int m_hum, m_temp, m_err, m_retry;
    bit m_ok, m_fault, m_hot, m_cold, m_humid, m_new, m_backoff;

    typedef struct {
        int hum;
        int temp;
        bit hot;
        bit cold;
        bit humid;
    } hyst_vec_t;
    hyst_vec_t hv[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hum = 0; m_temp = 0; m_err = 0; m_retry = 0;
        m_ok = 0; m_fault = 0; m_hot = 0; m_cold = 0; m_humid = 0;
        m_new = 0; m_backoff = 0;
    endtask

    task automatic model_attempt(input bit responded, input bit v, input int h, input int t);
        if (responded && v && h <= 100 && t <= 60) begin
            m_hum = h; m_temp = t; m_ok = 1; m_fault = 0; m_retry = 0;
            m_new = 1; m_backoff = 0;
            if (t >= TH) m_hot = 1; else if (t < TH - HY) m_hot = 0;
            if (t <= TC) m_cold = 1; else if (t > TC + HY) m_cold = 0;
            if (h >= HH) m_humid = 1; else if (h < HH - HY) m_humid = 0;
        end else begin
            m_new = 0;
            m_err = (m_err >= 255) ? 255 : m_err + 1;
            m_retry++;
            if (m_retry <= MR) begin
                m_backoff = 1;
            end else begin
                m_fault = 1; m_ok = 0; m_retry = 0; m_backoff = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " hum_int"}, hum_int, m_hum);
        check({tag, " temp_int"}, temp_int, m_temp);
        check({tag, " data_ok"}, data_ok, m_ok);
        check({tag, " fault"}, fault, m_fault);
        check({tag, " err_count"}, err_count, m_err);
        check({tag, " too_hot"}, too_hot, m_hot);
        check({tag, " too_cold"}, too_cold, m_cold);
        check({tag, " too_humid"}, too_humid, m_humid);
        check({tag, " new_sample"}, new_sample, m_new);
        check({tag, " state"}, state, m_backoff ? 4 : 0);
    endtask

    task automatic do_reset(input bit en_v);
        rst = 1; req = 0; sens_done = 0; sens_valid = 0; en = 0;
        sens_hum = 16'h0; sens_temp = 16'h0;
        repeat (2) @(negedge clk);
        en = en_v; rst = 0;
        model_reset();
    endtask

    task automatic start_req(input string tag);
        req = 1;
        @(negedge clk);
        req = 0;
        check({tag, " sens_start after req"}, sens_start, 1);
    endtask

    // Returns -1 in the latency check when no start appears within the limit
    task automatic wait_start(input string tag, input int limit, input int exp_n);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (sens_start) seen = 1;
        end
        check({tag, " start latency"}, seen ? n : -1, exp_n);
    endtask

    // Entered on the START cycle; done is raised in WAIT cycle d; returns on
    // the cycle after EVAL, where results are visible.
    task automatic serve(input bit v, input int h, input int t, input int d);
        repeat (d + 1) @(negedge clk);
        sens_done = 1; sens_valid = v;
        sens_hum = {8'(h), 8'($urandom_range(0, 9))};
        sens_temp = {8'(t), 8'($urandom_range(0, 9))};
        @(negedge clk);
        sens_done = 0; sens_valid = 0;
        sens_hum = 16'($urandom); sens_temp = 16'($urandom);
        @(negedge clk);
        model_attempt(1, v, h, t);
    endtask

    task automatic silent_read();
        repeat (TO + 1) @(negedge clk);
        model_attempt(0, 0, 0, 0);
    endtask

    initial begin
        int s1, s2, s3;
        hv = '{
            '{50, 30, 1, 0, 0}, '{50, 29, 1, 0, 0}, '{50, 28, 1, 0, 0}, '{50, 27, 0, 0, 0},
            '{50, 15, 0, 1, 0}, '{50, 17, 0, 1, 0}, '{50, 18, 0, 0, 0},
            '{80, 20, 0, 0, 1}, '{79, 20, 0, 0, 1}, '{78, 20, 0, 0, 1}, '{77, 20, 0, 0, 0},
            '{100, 60, 1, 0, 1}, '{0, 0, 0, 1, 0}
        };

        // Reset state
        do_reset(0);
        check_model("reset");
        check("reset sens_start", sens_start, 0);

        // Good read
        start_req("good");
        serve(1, 8'h37, 8'h19, 0);
        check("good hum_int", hum_int, 55);
        check("good temp_int", temp_int, 25);
        check("good new_sample", new_sample, 1);
        check("good data_ok", data_ok, 1);
        check_model("good");
        @(negedge clk);
        check("good new_sample one cycle", new_sample, 0);

        // Checksum failure then success
        do_reset(0);
        start_req("cksum");
        serve(0, 55, 25, 2);
        check("cksum err_count", err_count, 1);
        check("cksum state backoff", state, 4);
        check_model("cksum fail");
        wait_start("cksum retry", 40, GAP);
        serve(1, 55, 25, 1);
        check("cksum fault", fault, 0);
        check_model("cksum ok");

        // Hysteresis table
        do_reset(0);
        for (int i = 0; i < 13; i++) begin
            start_req("hyst");
            serve(1, hv[i].hum, hv[i].temp, i % 4);
            check($sformatf("hyst[%0d] too_hot", i), too_hot, hv[i].hot);
            check($sformatf("hyst[%0d] too_cold", i), too_cold, hv[i].cold);
            check($sformatf("hyst[%0d] too_humid", i), too_humid, hv[i].humid);
            check($sformatf("hyst[%0d] temp_int", i), temp_int, hv[i].temp);
            check($sformatf("hyst[%0d] hum_int", i), hum_int, hv[i].hum);
        end

        // Reader silent: four attempts, then fault with values held
        do_reset(0);
        start_req("silent pre");
        serve(1, 55, 25, 0);
        start_req("silent");
        for (int a = 0; a <= MR; a++) begin
            if (a > 0) wait_start("silent retry", 40, GAP);
            silent_read();
            check_model("silent");
        end
        check("silent err_count", err_count, 4);
        check("silent fault", fault, 1);
        check("silent data_ok", data_ok, 0);
        check("silent hum held", hum_int, 55);
        wait_start("silent no more", 40, -1);

        // Implausible humidity: rejected, retried, outputs unchanged
        start_req("implaus");
        serve(1, 120, 25, 3);
        check("implaus state backoff", state, 4);
        check("implaus hum held", hum_int, 55);
        check("implaus new_sample", new_sample, 0);
        check_model("implaus");
        wait_start("implaus retry", 40, GAP);
        serve(1, 40, 22, 0);
        check_model("implaus recover");

        // Done arriving on the timeout cycle still counts as done
        start_req("edge");
        serve(1, 33, 21, TO - 1);
        check("edge done wins new_sample", new_sample, 1);
        check_model("edge");

        // req during WAIT is ignored
        start_req("reqwait");
        @(negedge clk); req = 1;
        @(negedge clk); req = 0;
        serve(1, 44, 23, 2);
        check_model("reqwait");
        wait_start("reqwait no extra", 30, -1);

        // sens_done outside WAIT is ignored
        sens_done = 1; sens_valid = 1; sens_hum = 16'h5A00; sens_temp = 16'h1400;
        @(negedge clk);
        sens_done = 0; sens_valid = 0;
        check("stray done state", state, 0);
        @(negedge clk);
        check("stray done new_sample", new_sample, 0);
        check("stray done hum held", hum_int, m_hum);

        // Reset in the middle of WAIT
        start_req("rstwait");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rstwait state", state, 0);
        check("rstwait hum_int", hum_int, 0);
        check("rstwait temp_int", temp_int, 0);
        check("rstwait data_ok", data_ok, 0);
        check("rstwait err_count", err_count, 0);
        check("rstwait flags", {too_hot, too_cold, too_humid, fault, new_sample, sens_start}, 0);
        rst = 0;
        model_reset();

        // Periodic reads: first at P after reset, then P + attempt length
        do_reset(1);
        wait_start("period first", 2 * P, P);
        s1 = cyc;
        serve(1, 50, 20, 0);
        wait_start("period second", 2 * P, P);
        s2 = cyc;
        check("period interval d0", s2 - s1, P + 3);
        serve(1, 50, 20, 7);
        wait_start("period third", 2 * P, P);
        s3 = cyc;
        check("period interval d7", s3 - s2, P + 3 + 7);
        en = 0;
        serve(1, 50, 20, 0);

        // Randomized reads against the model
        do_reset(0);
        for (int i = 0; i < 40; i++) begin
            int h, t, d;
            bit v, quiet;
            if (m_backoff) wait_start("rnd retry", 40, GAP);
            else start_req("rnd");
            quiet = ($urandom_range(0, 9) == 0);
            v = ($urandom_range(0, 3) != 0);
            h = $urandom_range(70, 110);
            t = $urandom_range(0, 70);
            d = $urandom_range(0, TO - 1);
            if (quiet) silent_read();
            else serve(v, h, t, d);
            check_model($sformatf("rnd[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
